sccb_cfg_seq: RTL and testbench

- Camera register-configuration sequencer.
- Sits directly downstream of the power-up reset delay stage: it begins once the delayed camera-release signal is asserted.
- Walks an external register table and issues SCCB 3-phase write transactions (device ID, register address, data) on an open-drain SIOC/SIOD pair.
- Signals `done` so the DVP capture and UDP path can start on a configured sensor.

---
 rtl/sccb_cfg_seq.sv | 189 ++++++++++++++++++
 tb/tb_sccb_cfg_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_seq.sv
// rtl/sccb_cfg_seq.sv - camera register-table sequencer issuing SCCB 3-phase writes
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           level; launches the table walk from IDLE
//   cfg_idx         table index presented to the external ROM
//   cfg_data        {reg_addr, reg_data} returned by the ROM one clk after cfg_idx
//   sioc            SCCB clock, push-pull
//   siod_oe         1 = pull SIOD low, 0 = release
//   busy            high from launch until the table is finished
//   done            sticky high once the last entry has executed
module sccb_cfg_seq #(
    parameter int         CLK_DIV      = 125,
    parameter logic [7:0] DEV_ID       = 8'h42,
    parameter int         NUM_REGS     = 75,
    parameter int         DELAY_CYCLES = 500000,
    parameter bit         FAST_SIM     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  cfg_idx,
    input  logic [15:0] cfg_data,
    output logic        sioc,
    output logic        siod_oe,
    output logic        busy,
    output logic        done
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [31:0]      DLY_MAX  = FAST_SIM ? 32'd15 : 32'(DELAY_CYCLES - 1);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_START, S_SHIFT, S_STOP, S_GAP, S_DELAY, S_NEXT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [4:0]       bit_q, bit_d;
    logic [26:0]      shreg_q, shreg_d;
    logic             fetch_q, fetch_d;
    logic [31:0]      dly_q, dly_d;
    logic [7:0]       idx_q, idx_d;
    logic             sioc_q, sioc_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic bus_state;
    logic tick;
    logic bit_end;

    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        qtr_d    = '0;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        fetch_d  = fetch_q;
        dly_d    = dly_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = done_q;
        sioc_d   = 1'b1;
        oe_d     = 1'b0;

        // Quarter-bit timebase only runs in bus phases, so every phase starts at q0.
        bus_state = (state_q == S_START) || (state_q == S_SHIFT) ||
                    (state_q == S_STOP)  || (state_q == S_GAP);
        tick      = (div_q == DIV_MAX);
        bit_end   = tick && (qtr_q == 2'd3);
        if (bus_state) begin
            div_d = tick ? '0 : div_q + 1'b1;
            qtr_d = tick ? qtr_q + 2'd1 : qtr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    fetch_d = 1'b0;
                end
            end
            S_FETCH: begin
                // First clk lets the ROM see cfg_idx, second clk samples its output.
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                    // Acknowledge slots are shifted as 1 so SIOD stays released.
                    shreg_d = {DEV_ID, 1'b1, cfg_data[15:8], 1'b1, cfg_data[7:0], 1'b1};
                    if (cfg_data[15:8] == 8'hFF) begin
                        state_d = S_DELAY;
                        dly_d   = '0;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                sioc_d = (qtr_q < 2'd2);
                oe_d   = (qtr_q != 2'd0);
                if (bit_end) begin
                    state_d = S_SHIFT;
                    bit_d   = '0;
                end
            end
            S_SHIFT: begin
                sioc_d = qtr_q[1];
                oe_d   = ~shreg_q[26];
                if (bit_end) begin
                    if (bit_q == 5'd26) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shreg_d = {shreg_q[25:0], 1'b1};
                    end
                end
            end
            S_STOP: begin
                sioc_d = (qtr_q != 2'd0);
                oe_d   = (qtr_q < 2'd2);
                if (bit_end) state_d = S_GAP;
            end
            S_GAP: begin
                if (bit_end) state_d = S_NEXT;
            end
            S_DELAY: begin
                if (dly_q == DLY_MAX) state_d = S_NEXT;
                else                  dly_d   = dly_q + 32'd1;
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            fetch_q <= 1'b0;
            dly_q   <= '0;
            idx_q   <= '0;
            sioc_q  <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            fetch_q <= fetch_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            sioc_q  <= sioc_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cfg_idx = idx_q;
    assign sioc    = sioc_q;
    assign siod_oe = oe_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// tb/tb_sccb_cfg_seq.sv - scoreboard bench for sccb_cfg_seq
module tb_sccb_cfg_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_idx;
    logic [15:0] cfg_data = 16'h0000;
    logic        sioc, siod_oe, busy, done;

    logic [15:0] rom [0:2];
    logic [15:0] sb_q [$];

    int vectors = 0;
    int miscompares = 0;

    // Bus decoder state
    logic        prev_sioc = 1'b1;
    logic        prev_oe = 1'b0;
    logic        rst_prev = 1'b0;
    logic        in_frame = 1'b0;
    int          rise_cnt = 0;
    logic [27:0] acc = '0;
    int          frames = 0;
    int          viol = 0;
    int          sioc_edges = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cfg_data <= (cfg_idx < 8'd3) ? rom[cfg_idx[1:0]] : 16'h0000;

    sccb_cfg_seq #(
        .CLK_DIV(2), .DEV_ID(8'h42), .NUM_REGS(3), .DELAY_CYCLES(500000), .FAST_SIM(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .sioc(sioc), .siod_oe(siod_oe), .busy(busy), .done(done)
    );

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // acc layout: [27:20] dev, [19] X, [18:11] addr, [10] X, [9:2] data, [1] X, [0] stop rise
    task automatic check_frame();
        logic [15:0] exp;
        check("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check("data_bits", rise_cnt - 1, 27);
            check("dev_id", int'(acc[27:20]), 32'h42);
            check("reg_addr", int'(acc[18:11]), int'(exp[15:8]));
            check("reg_data", int'(acc[9:2]), int'(exp[7:0]));
        end
    endtask

    always @(negedge clk) begin
        if (rst || rst_prev) begin
            in_frame  = 1'b0;
            prev_sioc = sioc;
            prev_oe   = siod_oe;
        end else begin
            if (sioc != prev_sioc) sioc_edges++;
            if ((siod_oe != prev_oe) && sioc) begin
                if (!prev_sioc) begin
                    viol++;
                end else if (siod_oe) begin
                    in_frame = 1'b1;
                    rise_cnt = 0;
                    acc      = '0;
                end else if (in_frame) begin
                    in_frame = 1'b0;
                    frames++;
                    check_frame();
                end else begin
                    viol++;
                end
            end
            if (sioc && !prev_sioc && in_frame) begin
                rise_cnt++;
                acc = {acc[26:0], ~siod_oe};
            end
            prev_sioc = sioc;
            prev_oe   = siod_oe;
        end
        rst_prev = rst;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 5000 && !done; i++) @(negedge clk);
        @(negedge clk);
        check(name, int'(done), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sioc"}, int'(sioc), 1);
        check({tag, "_siod_oe"}, int'(siod_oe), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_cfg_idx"}, int'(cfg_idx), 0);
    endtask

    initial begin
        int chg;
        int t;
        int e0;
        int f0;
        rom[0] = 16'hFF55;
        rom[1] = 16'h3A04;
        rom[2] = 16'h1280;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        chg = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({sioc, siod_oe, busy, done, cfg_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) chg++;
        end
        check("idle_hold", chg, 0);

        // Run 1: delay entry, then two writes
        sb_q.push_back(16'h3A04);
        sb_q.push_back(16'h1280);
        pulse_start();
        @(negedge clk);
        check("launch_busy", int'(busy), 1);
        t = 0;
        while (sioc && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("delay_gap_ok", int'(t >= 20 && t <= 40), 1);
        wait_done("run1_done");
        check("run1_busy", int'(busy), 0);
        check("run1_last_idx", int'(cfg_idx), 2);
        check("run1_frames", frames, 2);
        check("run1_sb_empty", sb_q.size(), 0);
        check("run1_siod_timing", viol, 0);

        // start is ignored once done
        e0 = sioc_edges;
        f0 = frames;
        repeat (10) begin
            @(posedge clk); #1 start = ~start;
            repeat (15) @(posedge clk);
        end
        #1 start = 1'b0;
        @(negedge clk);
        check("post_done_edges", sioc_edges - e0, 0);
        check("post_done_frames", frames - f0, 0);
        check("post_done_done", int'(done), 1);
        check("post_done_busy", int'(busy), 0);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_from_done");

        // Run 2: reset during the shift of entry 2
        sb_q.push_back(16'h3A04);
        sb_q.push_back(16'h1280);
        pulse_start();
        t = 0;
        while (!(cfg_idx == 8'd1 && in_frame && rise_cnt >= 5) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reach_shift2", int'(t < 2000), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_reset");

        // Run 3: replay from entry 0 after the abort
        f0 = frames;
        sb_q.push_back(16'h3A04);
        sb_q.push_back(16'h1280);
        pulse_start();
        wait_done("run3_done");
        check("run3_frames", frames - f0, 2);
        check("run3_sb_empty", sb_q.size(), 0);
        check("run3_siod_timing", viol, 0);
        check("run3_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
